pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Staged reset release after PLL lock: holds both resets until lock is stable,
// releases rst_sys, then rst_core, then runs a clock-enable divider.
module pll_reset_sequencer #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned STAGGER     = 16,
    parameter int unsigned CE_DIV      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_reset,
    output logic       rst_sys,
    output logic       rst_core,
    output logic       ce,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned SW = $clog2(LOCK_CYCLES);
    localparam int unsigned TW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned DW = $clog2(CE_DIV);

    localparam logic [SW-1:0] SETTLE_LAST  = SW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER - 1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(CE_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        REL_SYS   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state;
    logic          lock_meta;
    logic          lock_s;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] stag_cnt;
    logic [DW-1:0] div_cnt;

    // Two-flop synchronizer; lock_s is the only consumer of pll_locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer: outputs change on the same edge as the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_LOCK;
            settle_cnt    <= '0;
            stag_cnt      <= '0;
            div_cnt       <= '0;
            rst_sys       <= 1'b1;
            rst_core      <= 1'b1;
            ce            <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            ce <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end

                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (sw_reset) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state    <= REL_SYS;
                        stag_cnt <= '0;
                        rst_sys  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end

                REL_SYS, RUN: begin
                    if (!lock_s) begin
                        // Lock loss wins over a concurrent sw_reset.
                        state    <= WAIT_LOCK;
                        div_cnt  <= '0;
                        rst_sys  <= 1'b1;
                        rst_core <= 1'b1;
                        ready    <= 1'b0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end else if (sw_reset) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        div_cnt    <= '0;
                        rst_sys    <= 1'b1;
                        rst_core   <= 1'b1;
                        ready      <= 1'b0;
                    end else if (state == REL_SYS) begin
                        if (stag_cnt == STAGGER_LAST) begin
                            state    <= RUN;
                            div_cnt  <= '0;
                            rst_core <= 1'b0;
                            ready    <= 1'b1;
                        end else begin
                            stag_cnt <= stag_cnt + TW'(1);
                        end
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ce      <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                default: begin
                    state    <= WAIT_LOCK;
                    rst_sys  <= 1'b1;
                    rst_core <= 1'b1;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

endmodule
